spi_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` instance among `NUM_REQ` requesters. It accepts per-requester transfer requests (TX, RX or full duplex), grants one at a time, and drives the master's `req`/`din`/`wait_duration` inputs. It tracks `done_tx`/`done_rx` to detect completion and returns read data with a one-cycle acknowledge. It sits between the requesting blocks and `spi_master`, and is clocked by the same `clk` and `rst`.

---
 rtl/spi_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one spi_master among NUM_REQ requesters. Requests are granted one at
// a time in round-robin order, searching upward from the last winner. Each
// transfer is sequenced through IDLE -> ISSUE -> ACTIVE -> COMPLETE, and the
// requester gets a one-cycle acknowledge carrying the read data and an error
// flag.
//
// Handshake: a requester raises rq_valid[i] with its op/data/wait and holds it
// until rq_ack[i]. The op, data and wait are captured only at the grant edge.
// rq_ack is a one-cycle one-hot pulse, and rq_rdata/rq_err are valid only
// while an rq_ack bit is high. A requester that drops rq_valid after its grant
// is still sequenced and acknowledged.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a watchdog counter that
// aborts a transfer stuck in ISSUE/ACTIVE after TIMEOUT_CYCLES clocks. Without
// it the arbiter waits for done indefinitely.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rq_valid[NUM_REQ]     per-requester request
//   rq_op[2*NUM_REQ]      op per requester: 01 TX, 10 RX, 11 duplex, 00 illegal
//   rq_data, rq_wait      TX word and wait_duration per requester
//   rq_ack, rq_rdata,     completion pulse (one-hot), read word, error flag
//   rq_err
//   busy                  high from the grant edge through the ack cycle
//   m_req, m_din, m_wait  to the master's req / din / wait_duration
//   m_dout, m_done_tx,    from the master
//   m_done_rx, m_cs
//   dbg_state             current FSM state (IDLE=0 ISSUE=1 ACTIVE=2 COMPLETE=3)
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          SPI_TRF_BIT    = 12,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             rq_valid,
  input  logic [2*NUM_REQ-1:0]           rq_op,
  input  logic [SPI_TRF_BIT*NUM_REQ-1:0] rq_data,
  input  logic [8*NUM_REQ-1:0]           rq_wait,
  output logic [NUM_REQ-1:0]             rq_ack,
  output logic [SPI_TRF_BIT-1:0]         rq_rdata,
  output logic                           rq_err,
  output logic                           busy,
  output logic [1:0]                     m_req,
  output logic [SPI_TRF_BIT-1:0]         m_din,
  output logic [7:0]                     m_wait,
  input  logic [SPI_TRF_BIT-1:0]         m_dout,
  input  logic                           m_done_tx,
  input  logic                           m_done_rx,
  input  logic                           m_cs,
  output logic [1:0]                     dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_ACTIVE   = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          last_grant, last_grant_n;
  logic [IW-1:0]          win, win_n;
  logic [1:0]             op_q, op_n;
  logic                   tx_seen, tx_seen_n;
  logic                   rx_seen, rx_seen_n;
  logic [SPI_TRF_BIT-1:0] rx_word, rx_word_n;

  logic [NUM_REQ-1:0]     rq_ack_n;
  logic [SPI_TRF_BIT-1:0] rq_rdata_n;
  logic                   rq_err_n;
  logic                   busy_n;
  logic [1:0]             m_req_n;
  logic [SPI_TRF_BIT-1:0] m_din_n;
  logic [7:0]             m_wait_n;

  // Round-robin pick: first valid requester at or after last_grant+1, wrapping.
  logic                   rr_found;
  logic [IW-1:0]          rr_idx;
  logic [IW-1:0]          rr_cidx;
  int                     rr_cand;
  logic [1:0]             rr_op;
  logic [SPI_TRF_BIT-1:0] rr_data;
  logic [7:0]             rr_wait;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    rr_cidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_cand = (int'(last_grant) + i + 1) % NUM_REQ;
      rr_cidx = rr_cand[IW-1:0];
      if (!rr_found && rq_valid[rr_cidx]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cidx;
      end
    end
    rr_op   = rq_op[{rr_idx, 1'b0} +: 2];
    rr_data = rq_data[rr_idx*SPI_TRF_BIT +: SPI_TRF_BIT];
    rr_wait = rq_wait[{rr_idx, 3'b000} +: 8];
  end

  // Watchdog: counts clocks spent in ISSUE/ACTIVE for the current grant.
  logic tmo_hit;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE || state == S_ACTIVE) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == S_ISSUE || state == S_ACTIVE) &&
                   ((tmo_cnt + 16'd1) >= TIMEOUT_CYCLES);
`else
  assign tmo_hit = 1'b0;
`endif

  // Completion test: the current done pulses count together with the sticky
  // flags, so a duplex op finishes on whichever done arrives last.
  logic tx_ok, rx_ok, op_done;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    win_n        = win;
    op_n         = op_q;
    tx_seen_n    = tx_seen;
    rx_seen_n    = rx_seen;
    rx_word_n    = rx_word;
    m_req_n      = m_req;
    m_din_n      = m_din;
    m_wait_n     = m_wait;
    busy_n       = busy;
    rq_ack_n     = '0;
    rq_rdata_n   = '0;
    rq_err_n     = 1'b0;
    tx_ok        = tx_seen | m_done_tx;
    rx_ok        = rx_seen | m_done_rx;
    op_done      = (!op_q[0] || tx_ok) && (!op_q[1] || rx_ok);

    case (state)
      S_IDLE: begin
        m_req_n = 2'b00;
        if (m_cs && rr_found) begin
          win_n     = rr_idx;
          op_n      = rr_op;
          tx_seen_n = 1'b0;
          rx_seen_n = 1'b0;
          rx_word_n = '0;
          busy_n    = 1'b1;
          if (rr_op == 2'b00) begin
            // Illegal op: acknowledge with error, never touch the master.
            state_n          = S_COMPLETE;
            rq_ack_n[rr_idx] = 1'b1;
            rq_err_n         = 1'b1;
          end else begin
            state_n  = S_ISSUE;
            m_req_n  = rr_op;
            m_din_n  = rr_data;
            m_wait_n = rr_wait;
          end
        end
      end

      S_ISSUE: begin
        if (tmo_hit) begin
          m_req_n       = 2'b00;
          state_n       = S_COMPLETE;
          rq_ack_n[win] = 1'b1;
          rq_err_n      = 1'b1;
        end else if (!m_cs) begin
          // The master has taken the request; drop it so it is not repeated.
          m_req_n = 2'b00;
          state_n = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        tx_seen_n = tx_ok;
        rx_seen_n = rx_ok;
        if (m_done_rx) begin
          rx_word_n = m_dout;
        end
        if (op_done) begin
          state_n       = S_COMPLETE;
          rq_ack_n[win] = 1'b1;
          if (op_q[1]) begin
            rq_rdata_n = m_done_rx ? m_dout : rx_word;
          end
        end else if (tmo_hit) begin
          state_n       = S_COMPLETE;
          rq_ack_n[win] = 1'b1;
          rq_err_n      = 1'b1;
        end
      end

      S_COMPLETE: begin
        // rq_ack is high during this state; close out and rearm.
        last_grant_n = win;
        tx_seen_n    = 1'b0;
        rx_seen_n    = 1'b0;
        busy_n       = 1'b0;
        state_n      = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      win        <= '0;
      op_q       <= 2'b00;
      tx_seen    <= 1'b0;
      rx_seen    <= 1'b0;
      rx_word    <= '0;
      rq_ack     <= '0;
      rq_rdata   <= '0;
      rq_err     <= 1'b0;
      busy       <= 1'b0;
      m_req      <= 2'b00;
      m_din      <= '0;
      m_wait     <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      win        <= win_n;
      op_q       <= op_n;
      tx_seen    <= tx_seen_n;
      rx_seen    <= rx_seen_n;
      rx_word    <= rx_word_n;
      rq_ack     <= rq_ack_n;
      rq_rdata   <= rq_rdata_n;
      rq_err     <= rq_err_n;
      busy       <= busy_n;
      m_req      <= m_req_n;
      m_din      <= m_din_n;
      m_wait     <= m_wait_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Directed and randomized test of spi_master_arbiter. A behavioural master
// responds to m_req (cs falls two clocks after it latches the request, done
// pulses after a programmable frame length, RX word = din ^ key). The
// reference model keeps pending requests in arrays, picks winners with plain
// round-robin arithmetic and predicts ack, read data, error and frame count.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;

  localparam int N = 4;
  localparam int W = 12;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'd50;
`else
  localparam logic [15:0] TMO = 16'd4096;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic [N-1:0]   rq_valid;
  logic [2*N-1:0] rq_op;
  logic [W*N-1:0] rq_data;
  logic [8*N-1:0] rq_wait;
  logic [N-1:0]   rq_ack;
  logic [W-1:0]   rq_rdata;
  logic           rq_err;
  logic           busy;
  logic [1:0]     m_req;
  logic [W-1:0]   m_din;
  logic [7:0]     m_wait;
  logic [W-1:0]   m_dout;
  logic           m_done_tx;
  logic           m_done_rx;
  logic           m_cs;
  logic [1:0]     dbg_state;

  spi_master_arbiter #(
    .NUM_REQ        (N),
    .SPI_TRF_BIT    (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rq_valid  (rq_valid),
    .rq_op     (rq_op),
    .rq_data   (rq_data),
    .rq_wait   (rq_wait),
    .rq_ack    (rq_ack),
    .rq_rdata  (rq_rdata),
    .rq_err    (rq_err),
    .busy      (busy),
    .m_req     (m_req),
    .m_din     (m_din),
    .m_wait    (m_wait),
    .m_dout    (m_dout),
    .m_done_tx (m_done_tx),
    .m_done_rx (m_done_rx),
    .m_cs      (m_cs),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [1:0]   mo [N];
  logic [W-1:0] md [N];
  logic [7:0]   mw [N];
  logic [N-1:0] pend;
  int           last_g;
  int           exp_frames;
  int           lat;
  logic [W+1:0] exp_q [$];   // {err, ack_idx_valid, rdata} per expected ack

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  // ---------------- behavioural master ----------------
  int           frames;
  logic [1:0]   f_op;
  logic [W-1:0] f_din;
  logic [7:0]   f_wait;
  logic [W-1:0] key;
  int           frame_len;
  int           dup_gap;
  bit           stall_rx;
  int           m_phase, m_cnt, t_tx, t_rx, last_t;

  initial begin
    m_cs = 1'b1; m_done_tx = 1'b0; m_done_rx = 1'b0; m_dout = '0;
    m_phase = 0; frames = 0; m_cnt = 0; t_tx = 0; t_rx = 0; last_t = 0;
    f_op = 2'b00; f_din = '0; f_wait = '0;
    forever begin
      @(negedge clk);
      m_done_tx = 1'b0;
      m_done_rx = 1'b0;
      if (rst) begin
        m_phase = 0;
        m_cs    = 1'b1;
      end else begin
        case (m_phase)
          0: if (m_req != 2'b00) begin
               f_op = m_req; f_din = m_din; f_wait = m_wait;
               frames++;
               check("busy_at_grant", busy, 1);
               m_phase = 1;
             end
          1: begin
               check("req_hold_latch", m_req, f_op);
               m_phase = 2;
             end
          2: begin
               check("req_hold_cs", m_req, f_op);
               m_cs   = 1'b0;
               m_cnt  = 0;
               t_tx   = frame_len;
               t_rx   = (f_op == 2'b11) ? frame_len + dup_gap : frame_len;
               last_t = f_op[1] ? t_rx : t_tx;
               m_phase = 3;
             end
          3: begin
               check("req_low_while_cs_low", m_req, 0);
               if (stall_rx) begin
                 if (rq_ack != '0) begin
                   m_cs = 1'b1;
                   m_phase = 0;
                 end else begin
                   m_cnt++;
                 end
               end else begin
                 check("no_early_ack", rq_ack, 0);
                 m_cnt++;
                 if (f_op[0] && m_cnt == t_tx) m_done_tx = 1'b1;
                 if (f_op[1] && m_cnt == t_rx) begin
                   m_done_rx = 1'b1;
                   m_dout    = f_din ^ key;
                 end
                 if (m_cnt == last_t) m_phase = 4;
               end
             end
          default: begin
               check("ack_after_final_done", {31'b0, |rq_ack}, 1);
               m_cs = 1'b1;
               m_phase = 0;
             end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] data,
                         input logic [7:0] wt);
    mo[i] = op; md[i] = data; mw[i] = wt;
    pend[i] = 1'b1;
    rq_op[2*i +: 2]   = op;
    rq_data[W*i +: W] = data;
    rq_wait[8*i +: 8] = wt;
    rq_valid[i]       = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_ack",    rq_ack,    0);
    check("rst_rdata",  rq_rdata,  0);
    check("rst_err",    rq_err,    0);
    check("rst_busy",   busy,      0);
    check("rst_m_req",  m_req,     0);
    check("rst_m_din",  m_din,     0);
    check("rst_m_wait", m_wait,    0);
    check("rst_state",  dbg_state, 0);
  endtask

  // Serve every pending request and compare each ack with the model.
  task automatic run_pending();
    int w, cyc;
    logic [W+1:0] e;
    while (pend != '0) begin
      w = rr_pick(pend, last_g);
      e = {(mo[w] == 2'b00), 1'b1, (mo[w][1] ? (md[w] ^ key) : {W{1'b0}})};
      exp_q.push_back(e);
      if (mo[w] != 2'b00) exp_frames++;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (rq_ack == '0 && cyc < 3000);
      lat = cyc;
      e = exp_q.pop_front();
      check("ack_seen", {31'b0, |rq_ack}, 1);
      if (rq_ack == '0) begin
        pend = '0;
        rq_valid = '0;
        return;
      end
      check("ack_winner", rq_ack, 32'(1) << w);
      check("ack_rdata", rq_rdata, e[W-1:0]);
      check("ack_err", rq_err, e[W+1]);
      check("frame_count", frames, exp_frames);
      if (mo[w] != 2'b00) begin
        check("frame_op", f_op, mo[w]);
        check("frame_din", f_din, md[w]);
        check("frame_wait", f_wait, mw[w]);
      end else begin
        check("err_ack_fast", {31'b0, (cyc < 4)}, 1);
        check("err_cs_high", m_cs, 1);
      end
      rq_valid[w] = 1'b0;
      rq_valid    = rq_valid & ~rq_ack;
      pend[w]     = 1'b0;
      last_g      = w;
      @(negedge clk);
      check("ack_one_cycle", rq_ack, 0);
      check("busy_clear", busy, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq_valid = '0;
    pend = '0;
    last_g = N - 1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    exp_frames = frames;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    rst = 1'b1; rq_valid = '0; rq_op = '0; rq_data = '0; rq_wait = '0;
    pend = '0; last_g = N - 1; exp_frames = 0; lat = 0;
    key = '0; frame_len = 6; dup_gap = 0; stall_rx = 1'b0;
    for (int i = 0; i < N; i++) begin
      mo[i] = 2'b00; md[i] = '0; mw[i] = '0;
    end

    // Reset state
    do_reset();

    // Single TX on requester 2; inputs scrambled and valid dropped after grant
    key = W'($urandom);
    set_req(2, 2'b01, 12'hA5C, 8'd3);
    @(negedge clk);
    check("busy_after_grant", busy, 1);
    rq_data[W*2 +: W] = 12'h000;
    rq_op[4 +: 2]     = 2'b11;
    rq_wait[16 +: 8]  = 8'hFF;
    rq_valid[2]       = 1'b0;
    run_pending();

    // Full duplex on requester 0, done_rx two clocks after done_tx
    key = 12'h123 ^ 12'hF0F;
    dup_gap = 2;
    set_req(0, 2'b11, 12'h123, 8'd1);
    run_pending();
    dup_gap = 0;

    // All four after reset: order 0,1,2,3; then 0 and 2 with last_grant=3
    do_reset();
    key = W'($urandom);
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom_range(1, 3)), W'($urandom), 8'($urandom));
    run_pending();
    set_req(0, 2'b10, W'($urandom), 8'd7);
    set_req(2, 2'b01, W'($urandom), 8'd2);
    run_pending();

    // Illegal op on requester 1
    set_req(1, 2'b00, 12'h777, 8'd5);
    run_pending();

    // Reset in the middle of an RX transfer
    stall_rx = 1'b1;
    set_req(3, 2'b10, W'($urandom), 8'd4);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (m_cs != 1'b0 && cyc < 100);
    check("rx_cs_low", m_cs, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    check("rst_no_ack", rq_ack, 0);
    stall_rx = 1'b0;
    rq_valid = '0;
    pend = '0;
    last_g = N - 1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_ack_after", rq_ack, 0);
    exp_frames = frames;
    key = W'($urandom);
    set_req(3, 2'b10, W'($urandom), 8'd9);
    run_pending();

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: stalled RX is aborted with an error
    stall_rx = 1'b1;
    set_req(1, 2'b10, W'($urandom), 8'd1);
    exp_frames++;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rq_ack == '0 && cyc < 500);
    check("tmo_ack", rq_ack, 4'b0010);
    check("tmo_err", rq_err, 1);
    check("tmo_rdata", rq_rdata, 0);
    check("tmo_latency", {31'b0, (cyc >= 49 && cyc <= 53)}, 1);
    check("tmo_frames", frames, exp_frames);
    rq_valid = '0;
    pend = '0;
    last_g = 1;
    stall_rx = 1'b0;
    @(negedge clk);
    check("tmo_ack_clear", rq_ack, 0);
`endif

    // Randomized batches
    for (int b = 0; b < 10; b++) begin
      key       = W'($urandom);
      frame_len = $urandom_range(3, 12);
      dup_gap   = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(i, 2'($urandom_range(0, 3)), W'($urandom), 8'($urandom));
      end
      if (pend == '0) set_req($urandom_range(0, N - 1), 2'b11, W'($urandom), 8'($urandom));
      run_pending();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
